// File: rtl/counter_updown_mod.sv
// W-bit up/down counter: programmable terminal value, parallel load,
// carry-in cascade enable and combinational terminal-count output.
//
// Ports:
//   ck    - clock (rising edge)
//   cl_n  - synchronous active-low reset (q<=0, top<=TOP_RST)
//   en/ci - count only when both are high
//   ud    - direction, 0 = up, 1 = down
//   ld/x  - parallel load of x into q (beats counting)
//   wt/t  - write t into the top register
//   q     - count state, top - current terminal value
//   c     - terminal count / carry-out for chaining
//
// Define COUNTER_UPDOWN_MOD_SAT_EN to saturate at 0 / top instead of
// wrapping. The default build wraps.
module counter_updown_mod #(
  parameter int unsigned W       = 4,
  parameter int unsigned TOP_RST = (1 << W) - 1
) (
  input  logic         ck,
  input  logic         cl_n,
  input  logic         en,
  input  logic         ci,
  input  logic         ud,
  input  logic         ld,
  input  logic [W-1:0] x,
  input  logic         wt,
  input  logic [W-1:0] t,
  output logic [W-1:0] q,
  output logic [W-1:0] top,
  output logic         c
);

  localparam logic [W-1:0] L_TOP_RST = W'(TOP_RST);

  logic [W-1:0] r_q;
  logic [W-1:0] r_top;
  logic [W-1:0] w_q_nxt;
  logic         w_cnt;
  logic         w_at_top;
  logic         w_at_zero;

  assign w_cnt     = en & ci;
  // q above top (after an out-of-range load) is treated as at top
  assign w_at_top  = (r_q >= r_top);
  assign w_at_zero = (r_q == '0);

  // reset and load both suppress the carry-out
  assign c = cl_n & ~ld & w_cnt &
             ((~ud & w_at_top) | (ud & w_at_zero));

  always_comb begin
    w_q_nxt = r_q;
    if (ld) begin
      w_q_nxt = x;
    end else if (w_cnt) begin
      if (!ud) begin
        if (w_at_top) begin
`ifdef COUNTER_UPDOWN_MOD_SAT_EN
          w_q_nxt = r_top;
`else
          w_q_nxt = '0;
`endif
        end else begin
          w_q_nxt = r_q + W'(1);
        end
      end else begin
        if (w_at_zero) begin
`ifdef COUNTER_UPDOWN_MOD_SAT_EN
          w_q_nxt = '0;
`else
          w_q_nxt = r_top;
`endif
        end else begin
          w_q_nxt = r_q - W'(1);
        end
      end
    end
  end

  // q next-state is computed from the old top, so a same-cycle
  // top write only affects later counts
  always_ff @(posedge ck) begin
    if (!cl_n) begin
      r_q   <= '0;
      r_top <= L_TOP_RST;
    end else begin
      r_q <= w_q_nxt;
      if (wt) begin
        r_top <= t;
      end
    end
  end

  assign q   = r_q;
  assign top = r_top;

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the lesson-7 reversible counter.
- W-bit up/down counter with:
  - a runtime-programmable terminal value (modulus = top+1), so mod-10 and similar counters need no redesign;
  - parallel load;
  - a carry-in enable for cascading;
  - a terminal-count output for chaining.
- Used as a generic sequencing and timing counter in the sequential-subsystems lessons and later designs.

Parameters:
- W, 4, counter width in bits (W >= 1).
- TOP_RST, 2**W-1, value of the internal `top` register after reset. It must fit in W bits.

Ports:
- ck  input  1  clock; all state changes on its rising edge.
- cl_n  input  1  reset. Synchronous, active-low.
- en  input  1  count enable.
- ci  input  1  carry-in. Counting happens only when en & ci. Tie to 1 when unused.
- ud  input  1  direction: 0 = up, 1 = down.
- ld  input  1  synchronous parallel load of x into q.
- x  input  W  load value.
- wt  input  1  synchronous write of t into the top register.
- t  input  W  new terminal value (last count value counting up).
- q  output  W  count state (registered).
- top  output  W  current terminal value (registered).
- c  output  1  terminal-count/carry-out (combinational).

Behaviour:
- Reset and priority on each rising edge of ck, highest first:
  - cl_n=0: q<=0, top<=TOP_RST. Reset overrides ld, wt, en and ci.
  - ld=1: q<=x, whatever en, ci and ud are.
  - en&ci=1, ud=0: if q>=top then q<=0, else q<=q+1.
  - en&ci=1, ud=1: if q==0 then q<=top, else q<=q-1.
  - Otherwise q holds.
- Top register:
  - wt=1 (with cl_n=1): top<=t.
  - This is independent of ld and counting in the same cycle.
  - The q update in that cycle uses the old top.
- Terminal count:
  - c = en & ci & ((~ud & (q>=top)) | (ud & (q==0))).
  - c is combinational, so it asserts in the same cycle as the state that wraps.
  - c is 0 whenever cl_n=0 or ld=1.
  - Chaining a second counter: drive its ci from the first counter's c.
- Boundary rules:
  - top=0: q stays 0 while counting, and c=en&ci every cycle.
  - Loaded x>top, counting up: the next count gives 0 (the q>=top rule) with c=1.
  - Loaded x>top, counting down: q decrements normally until it reaches 0, then wraps to top.
  - top=2**W-1: plain binary counter with natural wrap.
  - Changing ud mid-count takes effect on the next enabled edge, with no lost count.
  - cl_n low mid-count: q=0 and top=TOP_RST after that edge.
- Width rules:
  - All arithmetic is W bits, unsigned.
  - q-1 is never evaluated at q==0.
- Latency: q and top update one edge after their inputs. c has no latency.

Optional Feature:
- Macro: COUNTER_UPDOWN_MOD_SAT_EN.
- With the macro defined, the counter saturates instead of wrapping:
  - Counting up with q>=top: q<=top. A loaded x>top is also clamped to top on the next up-count.
  - Counting down with q==0: q holds 0.
  - c keeps exactly the same equation, so it stays asserted while saturated and enabled.
- Without the macro: wrap behaviour as described in Behaviour.

Test Plan:
- Up-count and wrap: W=4; cl_n=0 for one edge, then wt=1 with t=9, then en=ci=1, ud=0 for 12 edges.
  - Expected q: 0,1,…,9,0,1. c=1 only while q=9.
- Down-count and wrap: from q=2 with top=9, ud=1 for 4 edges.
  - Expected q: 1,0,9,8. c=1 only while q=0.
- Load priority: in one cycle set ld=1, x=6, en=1, ud=0.
  - Expected: q=6 next and c=0 during that cycle. Then cl_n=0 together with ld=1 gives q=0 and top=15.
- Out-of-range load: top=9, load x=13.
  - Up: the next enabled edge gives q=0, with c=1 beforehand.
  - Down instead: 12,11,…
  - With COUNTER_UPDOWN_MOD_SAT_EN: up gives q=9, and q holds at 9 with c=1.
- Cascade: two instances with W=4, top=15; the low counter's c drives the high counter's ci; count up for 40 edges.
  - Expected: {qh,ql}=40 (8'h28). qh increments exactly when ql goes 15→0.
- Degenerate and dynamic top:
  - top=0 with en=1: q stays 0 and c=1 every cycle.
  - At q=5 with top=9, write t=3: the next up-count gives 6 (old top used in the write cycle), and the count after that gives 0.
